// File: rtl/point_cache_loader.sv
// point_cache_loader: loads a core cache of consecutive points from point
// memory, streams fixed-size feeder blocks that wrap around the point cloud,
// and on controller completion retires outliers from a FIFO by zeroing them.
module point_cache_loader #(
  parameter int N                = 16,
  parameter int CORE_NUMBER      = 4,
  parameter int DISTANCE_MODULES = 4,
  parameter int ADDR_W           = 17
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             point_cloud_size,
  input  logic [ADDR_W-1:0]             point_pos,
  input  logic                          update_cache,
  input  logic                          controller_done,
  input  logic                          fifo_empty,
  input  logic [ADDR_W-1:0]             outlier_pos,
  output logic                          read_fifo,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [3*N-1:0]                mem_rdata,
  output logic                          mem_we,
  output logic [3*N-1:0]                mem_wdata,
  output logic [N*CORE_NUMBER-1:0]      cache_x,
  output logic [N*CORE_NUMBER-1:0]      cache_y,
  output logic [N*CORE_NUMBER-1:0]      cache_z,
  output logic                          cache_updated,
  output logic [N*DISTANCE_MODULES-1:0] cache_feeder_x,
  output logic [N*DISTANCE_MODULES-1:0] cache_feeder_y,
  output logic [N*DISTANCE_MODULES-1:0] cache_feeder_z,
  output logic                          feeder_valid,
  input  logic                          feeder_ready,
  output logic                          pause,
  output logic                          frame_done,
  output logic [ADDR_W-1:0]             outlier_count
);

  localparam int MAX_SLOTS = (CORE_NUMBER > DISTANCE_MODULES) ? CORE_NUMBER : DISTANCE_MODULES;
  localparam int CW        = $clog2(MAX_SLOTS + 2);

  localparam logic [CW-1:0] CN_LAST = CW'(CORE_NUMBER);
  localparam logic [CW-1:0] CN_DONE = CW'(CORE_NUMBER + 1);
  localparam logic [CW-1:0] DM_LAST = CW'(DISTANCE_MODULES);

  typedef enum logic [2:0] {
    IDLE,
    CORE_FILL,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] core_base;
  logic [ADDR_W-1:0] feeder_pos;
  logic              feeder_hold;
  logic              pend_v;
  logic              pend_core;
  logic [CW-1:0]     pend_slot;

  logic              issue;
  logic              enter_fill;
  logic [ADDR_W:0]   rd_idx;
  logic [ADDR_W:0]   size_w;
  logic [ADDR_W:0]   next_pos_w;

  // Indices are compared one bit wider so base+k never wraps into range.
  assign size_w     = {1'b0, point_cloud_size};
  assign next_pos_w = {1'b0, feeder_pos} + (ADDR_W+1)'(DISTANCE_MODULES);

  // Next-state decode, memory/FIFO strobes and handshake outputs.
  always_comb begin
    state_next    = state;
    enter_fill    = 1'b0;
    issue         = 1'b0;
    rd_idx        = '0;
    read_fifo     = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    cache_updated = 1'b0;
    feeder_valid  = 1'b0;
    frame_done    = 1'b0;
    pause         = 1'b1;
    case (state)
      IDLE: begin
        pause = 1'b0;
        if (start) begin
          state_next = CORE_FILL;
          enter_fill = 1'b1;
        end
      end
      CORE_FILL: begin
        if (controller_done) begin
          state_next = DRAIN;
        end else begin
          if (cnt < CN_LAST) begin
            rd_idx   = {1'b0, core_base} + (ADDR_W+1)'(cnt);
            mem_addr = rd_idx[ADDR_W-1:0];
            issue    = (rd_idx < size_w);
          end
          if (cnt == CN_DONE) begin
            cache_updated = 1'b1;
            state_next    = FEED;
          end
        end
      end
      FEED: begin
        if (controller_done) begin
          state_next = DRAIN;
        end else if (update_cache) begin
          state_next = CORE_FILL;
          enter_fill = 1'b1;
        end else begin
          feeder_valid = feeder_hold;
          if (!feeder_hold && (cnt < DM_LAST)) begin
            rd_idx   = {1'b0, feeder_pos} + (ADDR_W+1)'(cnt);
            mem_addr = rd_idx[ADDR_W-1:0];
            issue    = (rd_idx < size_w);
          end
        end
        pause = !feeder_valid;
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_next = DONE;
        end else begin
          read_fifo = 1'b1;
          mem_addr  = outlier_pos;
          mem_we    = (outlier_pos != '0) && (outlier_pos < point_cloud_size);
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counters, read-landing into cache slots and outlier counting.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      core_base      <= '0;
      feeder_pos     <= '0;
      feeder_hold    <= 1'b0;
      pend_v         <= 1'b0;
      pend_core      <= 1'b0;
      pend_slot      <= '0;
      outlier_count  <= '0;
      cache_x        <= '0;
      cache_y        <= '0;
      cache_z        <= '0;
      cache_feeder_x <= '0;
      cache_feeder_y <= '0;
      cache_feeder_z <= '0;
    end else begin
      state     <= state_next;
      pend_v    <= issue;
      pend_core <= (state == CORE_FILL);
      pend_slot <= cnt;

      // A landing read only counts if we are still in the phase that issued it.
      if (pend_v && pend_core && (state == CORE_FILL)) begin
        cache_x[N*int'(pend_slot) +: N] <= mem_rdata[N-1:0];
        cache_y[N*int'(pend_slot) +: N] <= mem_rdata[2*N-1:N];
        cache_z[N*int'(pend_slot) +: N] <= mem_rdata[3*N-1:2*N];
      end
      if (pend_v && !pend_core && (state == FEED)) begin
        cache_feeder_x[N*int'(pend_slot) +: N] <= mem_rdata[N-1:0];
        cache_feeder_y[N*int'(pend_slot) +: N] <= mem_rdata[2*N-1:N];
        cache_feeder_z[N*int'(pend_slot) +: N] <= mem_rdata[3*N-1:2*N];
      end

      case (state)
        IDLE: begin
          if (start) outlier_count <= '0;
        end
        CORE_FILL: begin
          cnt <= cnt + 1'b1;
          if (state_next == FEED) begin
            cnt         <= '0;
            feeder_pos  <= '0;
            feeder_hold <= 1'b0;
          end
        end
        FEED: begin
          if (!feeder_hold) begin
            if (cnt == DM_LAST) feeder_hold <= 1'b1;
            else                cnt         <= cnt + 1'b1;
          end else if (feeder_valid && feeder_ready) begin
            feeder_hold    <= 1'b0;
            cnt            <= '0;
            feeder_pos     <= (next_pos_w >= size_w) ? '0 : next_pos_w[ADDR_W-1:0];
            cache_feeder_x <= '0;
            cache_feeder_y <= '0;
            cache_feeder_z <= '0;
          end
        end
        DRAIN: begin
          if (mem_we) outlier_count <= outlier_count + 1'b1;
        end
        default: ;
      endcase

      // Placed last so a fresh fill wins over any read landing this cycle.
      if (enter_fill) begin
        cnt            <= '0;
        feeder_hold    <= 1'b0;
        core_base      <= point_pos;
        cache_x        <= '0;
        cache_y        <= '0;
        cache_z        <= '0;
        cache_feeder_x <= '0;
        cache_feeder_y <= '0;
        cache_feeder_z <= '0;
      end
    end
  end

endmodule

// File: tb/tb_point_cache_loader.sv
// Self-checking bench for point_cache_loader: point memory and outlier FIFO
// models, table-driven fill vectors, directed corner sequences, random frames.
module tb_point_cache_loader;

  localparam int N  = 16;
  localparam int CN = 4;
  localparam int DM = 4;
  localparam int AW = 17;

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic [AW-1:0]   point_cloud_size;
  logic [AW-1:0]   point_pos;
  logic            update_cache;
  logic            controller_done;
  logic            fifo_empty;
  logic [AW-1:0]   outlier_pos;
  logic            read_fifo;
  logic [AW-1:0]   mem_addr;
  logic [3*N-1:0]  mem_rdata;
  logic            mem_we;
  logic [3*N-1:0]  mem_wdata;
  logic [N*CN-1:0] cache_x;
  logic [N*CN-1:0] cache_y;
  logic [N*CN-1:0] cache_z;
  logic            cache_updated;
  logic [N*DM-1:0] cache_feeder_x;
  logic [N*DM-1:0] cache_feeder_y;
  logic [N*DM-1:0] cache_feeder_z;
  logic            feeder_valid;
  logic            feeder_ready;
  logic            pause;
  logic            frame_done;
  logic [AW-1:0]   outlier_count;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] fifo_mem [32];
  int fifo_rd = 0;
  int fifo_wr = 0;
  int wlog[$];
  int wdata_bad = 0;
  int wbase = 0;
  int fq[$];

  typedef struct {
    int size;
    int pp;
    int e0;
    int e1;
    int e2;
    int e3;
  } fill_vec_t;

  fill_vec_t vt [7];

  always #5 clock = ~clock;

  point_cache_loader #(
    .N(N),
    .CORE_NUMBER(CN),
    .DISTANCE_MODULES(DM),
    .ADDR_W(AW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .point_cloud_size(point_cloud_size),
    .point_pos(point_pos),
    .update_cache(update_cache),
    .controller_done(controller_done),
    .fifo_empty(fifo_empty),
    .outlier_pos(outlier_pos),
    .read_fifo(read_fifo),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .cache_x(cache_x),
    .cache_y(cache_y),
    .cache_z(cache_z),
    .cache_updated(cache_updated),
    .cache_feeder_x(cache_feeder_x),
    .cache_feeder_y(cache_feeder_y),
    .cache_feeder_z(cache_feeder_z),
    .feeder_valid(feeder_valid),
    .feeder_ready(feeder_ready),
    .pause(pause),
    .frame_done(frame_done),
    .outlier_count(outlier_count)
  );

  // Point i has a distinct nonzero {z,y,x} so zero slots are unambiguous.
  function automatic logic [47:0] pt(input int i);
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    x = 16'h1000 + 16'(i);
    y = 16'h2000 + 16'(i * 3);
    z = 16'h8000 ^ 16'(i * 7 + 1);
    return {z, y, x};
  endfunction

  // Four-slot image: slot k holds point base+k, or 0 when outside the cloud.
  function automatic logic [63:0] exp_slots(input int size, input int base, input int axis);
    logic [63:0] v;
    logic [47:0] p;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      if (base + k < size) begin
        p = pt(base + k);
        v[k*16 +: 16] = p[axis*16 +: 16];
      end
    end
    return v;
  endfunction

  // Same image built from an explicit list of point indices (-1 means empty).
  function automatic logic [63:0] exp_from_idx(input int e0, input int e1, input int e2,
                                               input int e3, input int axis);
    int e [4];
    logic [63:0] v;
    logic [47:0] p;
    e = '{e0, e1, e2, e3};
    v = '0;
    for (int k = 0; k < 4; k++) begin
      if (e[k] >= 0) begin
        p = pt(e[k]);
        v[k*16 +: 16] = p[axis*16 +: 16];
      end
    end
    return v;
  endfunction

  // Point memory with one-cycle read latency, write logger and FIFO pop.
  always @(posedge clock) begin
    mem_rdata <= pt(int'(mem_addr));
    if (mem_we) begin
      wlog.push_back(int'(mem_addr));
      if (mem_wdata != '0) wdata_bad++;
    end
    if (read_fifo && !fifo_empty) fifo_rd <= fifo_rd + 1;
  end

  assign fifo_empty  = (fifo_rd == fifo_wr);
  assign outlier_pos = fifo_mem[fifo_rd[4:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at the negedge of the first CORE_FILL cycle.
  task automatic wait_updated(input logic [63:0] ex, input logic [63:0] ey, input logic [63:0] ez);
    int cyc = 0;
    chk("fill_pause", 64'(pause), 64'd1);
    chk("fill_cleared", cache_x | cache_y | cache_z, 64'd0);
    while (!cache_updated && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("fill_latency", 64'(cyc), 64'd5);
    chk("cache_x", cache_x, ex);
    chk("cache_y", cache_y, ey);
    chk("cache_z", cache_z, ez);
  endtask

  task automatic do_fill(input int size, input int pp, input logic [63:0] ex,
                         input logic [63:0] ey, input logic [63:0] ez);
    point_cloud_size = AW'(size);
    point_pos        = AW'(pp);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("count_cleared", 64'(outlier_count), 64'd0);
    wait_updated(ex, ey, ez);
  endtask

  task automatic get_block(input int size, input int pos, input int hold);
    int cyc = 0;
    logic [63:0] ex;
    logic [63:0] ey;
    logic [63:0] ez;
    ex = exp_slots(size, pos, 0);
    ey = exp_slots(size, pos, 1);
    ez = exp_slots(size, pos, 2);
    while (!feeder_valid && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("feeder_valid_seen", 64'(feeder_valid), 64'd1);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(negedge clock);
        chk("feeder_valid_held", 64'(feeder_valid), 64'd1);
      end
      chk("feeder_x", cache_feeder_x, ex);
      chk("feeder_y", cache_feeder_y, ey);
      chk("feeder_z", cache_feeder_z, ez);
    end
    feeder_ready = 1'b1;
    @(negedge clock);
    feeder_ready = 1'b0;
    chk("feeder_cleared", cache_feeder_x | cache_feeder_y | cache_feeder_z, 64'd0);
    chk("feeder_valid_drop", 64'(feeder_valid), 64'd0);
  endtask

  task automatic load_fifo(input int size, output int nexp, inout int expw[$]);
    foreach (fq[i]) begin
      fifo_mem[fifo_wr[4:0]] = AW'(fq[i]);
      fifo_wr++;
      if (fq[i] != 0 && fq[i] < size) expw.push_back(fq[i]);
    end
    nexp = expw.size();
  endtask

  task automatic end_frame(input int size);
    int expw[$];
    int nexp;
    int cyc = 0;
    int got;
    wbase = wlog.size();
    load_fifo(size, nexp, expw);
    controller_done = 1'b1;
    @(negedge clock);
    controller_done = 1'b0;
    while (!frame_done && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    chk("frame_done_seen", 64'(frame_done), 64'd1);
    chk("outlier_count", 64'(outlier_count), 64'(nexp));
    got = wlog.size() - wbase;
    chk("write_count", 64'(got), 64'(nexp));
    for (int i = 0; i < nexp && i < got; i++) chk("write_addr", 64'(wlog[wbase + i]), 64'(expw[i]));
    chk("write_data_zero", 64'(wdata_bad), 64'd0);
    @(negedge clock);
    chk("frame_done_pulse", 64'(frame_done), 64'd0);
    chk("idle_pause", 64'(pause), 64'd0);
    chk("idle_read_fifo", 64'(read_fifo), 64'd0);
    fq.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 64'(|{read_fifo, mem_addr, mem_we, mem_wdata, cache_x, cache_y, cache_z,
                    cache_updated, cache_feeder_x, cache_feeder_y, cache_feeder_z,
                    feeder_valid, pause, frame_done, outlier_count}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int cyc;
    int snap;
    int size;
    int pp;
    int pos;
    int nb;
    int nf;

    reset            = 1'b1;
    start            = 1'b0;
    point_cloud_size = '0;
    point_pos        = '0;
    update_cache     = 1'b0;
    controller_done  = 1'b0;
    feeder_ready     = 1'b0;

    vt[0] = '{10, 0, 0, 1, 2, 3};
    vt[1] = '{10, 8, 8, 9, -1, -1};
    vt[2] = '{10, 6, 6, 7, 8, 9};
    vt[3] = '{10, 10, -1, -1, -1, -1};
    vt[4] = '{0, 0, -1, -1, -1, -1};
    vt[5] = '{3, 1, 1, 2, -1, -1};
    vt[6] = '{131071, 131069, 131069, 131070, -1, -1};

    repeat (3) @(negedge clock);
    chk_all_zero("reset_outputs");
    reset = 1'b0;
    @(negedge clock);

    // Table-driven core fills, each followed by one feeder block and an empty drain.
    foreach (vt[i]) begin
      do_fill(vt[i].size, vt[i].pp,
              exp_from_idx(vt[i].e0, vt[i].e1, vt[i].e2, vt[i].e3, 0),
              exp_from_idx(vt[i].e0, vt[i].e1, vt[i].e2, vt[i].e3, 1),
              exp_from_idx(vt[i].e0, vt[i].e1, vt[i].e2, vt[i].e3, 2));
      get_block(vt[i].size, 0, 0);
      end_frame(vt[i].size);
    end

    // Wrap-around feeder sequence on a six-point cloud with a held block.
    do_fill(6, 0, exp_slots(6, 0, 0), exp_slots(6, 0, 1), exp_slots(6, 0, 2));
    get_block(6, 0, 0);
    get_block(6, 4, 3);
    get_block(6, 0, 0);
    end_frame(6);

    // Reload request in the middle of a block fetch.
    do_fill(10, 0, exp_slots(10, 0, 0), exp_slots(10, 0, 1), exp_slots(10, 0, 2));
    repeat (2) @(negedge clock);
    point_pos    = AW'(4);
    update_cache = 1'b1;
    start        = 1'b1;
    @(negedge clock);
    update_cache = 1'b0;
    start        = 1'b0;
    chk("reload_valid_low", 64'(feeder_valid), 64'd0);
    wait_updated(exp_slots(10, 4, 0), exp_slots(10, 4, 1), exp_slots(10, 4, 2));
    get_block(10, 0, 1);
    end_frame(10);

    // Outlier FIFO with zero and out-of-range entries.
    do_fill(10, 0, exp_slots(10, 0, 0), exp_slots(10, 0, 1), exp_slots(10, 0, 2));
    fq = '{3, 0, 12, 7};
    end_frame(10);
    chk("outlier_count_two", 64'(outlier_count), 64'd2);
    chk("outlier_writes", 64'({wlog[wbase], wlog[wbase + 1]}), {32'd3, 32'd7});

    // Random frames against the reference image and FIFO filter.
    for (int r = 0; r < 20; r++) begin
      size = int'($urandom_range(0, 20));
      pp   = int'($urandom_range(0, 24));
      do_fill(size, pp, exp_slots(size, pp, 0), exp_slots(size, pp, 1), exp_slots(size, pp, 2));
      nb  = int'($urandom_range(1, 3));
      pos = 0;
      for (int b = 0; b < nb; b++) begin
        get_block(size, pos, int'($urandom_range(0, 2)));
        pos = (pos + DM >= size) ? 0 : pos + DM;
      end
      nf = int'($urandom_range(0, 5));
      for (int f = 0; f < nf; f++) fq.push_back(int'($urandom_range(0, 24)));
      end_frame(size);
    end

    // Reset with outliers still queued in DRAIN.
    do_fill(10, 0, exp_slots(10, 0, 0), exp_slots(10, 0, 1), exp_slots(10, 0, 2));
    wbase = wlog.size();
    fq = '{3, 5, 7, 9};
    foreach (fq[i]) begin
      fifo_mem[fifo_wr[4:0]] = AW'(fq[i]);
      fifo_wr++;
    end
    fq.delete();
    controller_done = 1'b1;
    @(negedge clock);
    controller_done = 1'b0;
    cyc = 0;
    while ((wlog.size() - wbase) < 2 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("drain_two_writes", 64'(wlog.size() - wbase), 64'd2);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_mem_we", 64'(mem_we), 64'd0);
    chk_all_zero("reset_drain_outputs");
    reset = 1'b0;
    snap = wlog.size();
    repeat (3) @(negedge clock);
    chk("reset_no_more_writes", 64'(wlog.size()), 64'(snap));
    chk("reset_idle_pause", 64'(pause), 64'd0);
    fifo_wr = fifo_rd;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
